// File: rtl/mem_vout_buffer_ctrl.sv
// Read-side frame fetcher: pulls completed frames from the DDR ring with
// burst reads, buffers them in a first-word-fall-through FIFO and streams
// them downstream. Advances rd_frame_addr_o for the write side's full check.
module mem_vout_buffer_ctrl #(
  parameter real TCQ             = 0.1,
  parameter int  ADDR_WIDTH      = 30,
  parameter int  MEM_DATA_BITS   = 512,
  parameter int  BURST_LEN       = 64,
  parameter int  FRAME_DEPTH_WID = 9,
  parameter int  LINE_WID        = 11,
  parameter int  FIFO_DEPTH      = 512
) (
  input  logic                            ddr_clk_i,
  input  logic                            ddr_rst_n_i,
  input  logic                            ddr_reset_flag_i,
  input  logic [FRAME_DEPTH_WID-1:0]      wr_frame_addr_i,
  output logic [FRAME_DEPTH_WID-1:0]      rd_frame_addr_o,
  output logic                            rd_ddr_req_o,
  output logic [7:0]                      rd_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]           rd_ddr_addr_o,
  input  logic                            rd_ddr_data_vld_i,
  input  logic [MEM_DATA_BITS-1:0]        rd_ddr_data_i,
  input  logic                            rd_ddr_finish_i,
  output logic                            vout_vld_o,
  output logic [MEM_DATA_BITS-1:0]        vout_data_o,
  input  logic                            vout_rdy_i,
  output logic                            frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]     vout_fifo_count_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int RAW_W = FRAME_DEPTH_WID + LINE_WID + 9;
  localparam logic [AW+1:0] SPACE_LIM = (AW+2)'(FIFO_DEPTH - BURST_LEN);
  localparam logic [AW:0]   BURST_AMT = (AW+1)'(BURST_LEN);
  localparam logic [AW:0]   ONE       = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE, FRAME_START, WAIT_SPACE, BURSTING, BURST_END, FRAME_END
  } state_t;

  state_t state, state_next;

  logic                     pend;
  logic [LINE_WID-1:0]      burst_line;
  logic [LINE_WID-1:0]      issue_line;
  logic [AW:0]              outst;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW+1:0]            used;
  logic [RAW_W-1:0]         raw_addr;
  logic [AW:0]              inc_amt, dec_amt;
  logic avail, space_ok, last_line, push, pop;
  logic issue, flush, line_clr, line_inc, frame_adv;

  assign avail      = (wr_frame_addr_i != rd_frame_addr_o);
  assign used       = {1'b0, vout_fifo_count_o} + {1'b0, outst};
  assign space_ok   = (used <= SPACE_LIM);
  assign last_line  = (burst_line == '1);
  assign vout_vld_o = (vout_fifo_count_o != '0) && !pend;
  assign vout_data_o = mem[rd_ptr];
  assign pop        = vout_vld_o && vout_rdy_i;
  assign push       = rd_ddr_data_vld_i && !pend;
  assign issue_line = line_clr ? '0 : burst_line;
  assign raw_addr   = {rd_frame_addr_o, issue_line, 9'd0};
  assign inc_amt    = issue ? BURST_AMT : '0;
  assign dec_amt    = (rd_ddr_data_vld_i && (outst != '0)) ? ONE : '0;

  // State register
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) state <= IDLE;
    else              state <= state_next;
  end

  // Next-state and per-cycle control strobes.
  // FRAME_START issues line 0 directly when space is available so the first
  // request leaves two cycles after a frame appears; otherwise it parks in
  // WAIT_SPACE exactly as a later line would.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    flush      = 1'b0;
    line_clr   = 1'b0;
    line_inc   = 1'b0;
    frame_adv  = 1'b0;
    case (state)
      IDLE: begin
        if (pend)       flush = 1'b1;
        else if (avail) state_next = FRAME_START;
      end
      FRAME_START: begin
        line_clr = 1'b1;
        if (pend) state_next = FRAME_END;
        else if (space_ok) begin
          issue      = 1'b1;
          state_next = BURSTING;
        end else state_next = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (pend) state_next = FRAME_END;
        else if (space_ok) begin
          issue      = 1'b1;
          state_next = BURSTING;
        end
      end
      BURSTING: begin
        if (rd_ddr_finish_i) state_next = BURST_END;
      end
      BURST_END: begin
        line_inc   = 1'b1;
        state_next = (last_line || pend) ? FRAME_END : WAIT_SPACE;
      end
      FRAME_END: begin
        frame_adv  = !pend;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request, pointers, credit, soft-reset flag and FIFO bookkeeping
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      pend              <= 1'b0;
      rd_frame_addr_o   <= '0;
      burst_line        <= '0;
      outst             <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      vout_fifo_count_o <= '0;
      rd_ddr_req_o      <= 1'b0;
      rd_ddr_len_o      <= '0;
      rd_ddr_addr_o     <= '0;
      frame_done_o      <= 1'b0;
    end else begin
      pend         <= (pend && !flush) || ddr_reset_flag_i;
      frame_done_o <= frame_adv;

      if (issue) begin
        rd_ddr_req_o  <= 1'b1;
        rd_ddr_len_o  <= 8'(BURST_LEN);
        rd_ddr_addr_o <= ADDR_WIDTH'(raw_addr);
      end else if (rd_ddr_req_o && (rd_ddr_data_vld_i || rd_ddr_finish_i)) begin
        rd_ddr_req_o <= 1'b0;
      end

      if (flush) begin
        rd_frame_addr_o   <= '0;
        burst_line        <= '0;
        outst             <= '0;
        wr_ptr            <= '0;
        rd_ptr            <= '0;
        vout_fifo_count_o <= '0;
      end else begin
        if (line_clr)      burst_line <= '0;
        else if (line_inc) burst_line <= burst_line + 1'b1;
        if (frame_adv) rd_frame_addr_o <= rd_frame_addr_o + 1'b1;
        outst <= outst + inc_amt - dec_amt;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   vout_fifo_count_o <= vout_fifo_count_o + ONE;
          2'b01:   vout_fifo_count_o <= vout_fifo_count_o - ONE;
          default: vout_fifo_count_o <= vout_fifo_count_o;
        endcase
      end
    end
  end

  // FIFO storage
  always_ff @(posedge ddr_clk_i) begin
    if (push) mem[wr_ptr] <= rd_ddr_data_i;
  end

endmodule

// File: tb/tb_mem_vout_buffer_ctrl.sv
// Directed bench for mem_vout_buffer_ctrl with a scaled-down geometry:
// 8-word bursts, 4 lines per frame, 16-word FIFO, 9-bit frame ring.
module tb_mem_vout_buffer_ctrl;

  localparam int DW  = 32;
  localparam int BL  = 8;
  localparam int LW  = 2;
  localparam int FD  = 16;
  localparam int FDW = 9;
  localparam int AWD = 30;
  localparam int CW  = $clog2(FD) + 1;
  localparam int LINES = 1 << LW;
  localparam int WPF   = BL * LINES;

  logic           clk, rst_n, flag;
  logic [FDW-1:0] wr_frame, rd_frame;
  logic           req, dvld, fin, vvld, rdy, done;
  logic [7:0]     len;
  logic [AWD-1:0] addr;
  logic [DW-1:0]  ddata, vdata;
  logic [CW-1:0]  cnt;

  int checks = 0, failures = 0;
  int nreq = 0, done_cnt = 0, words_out = 0, ovf_errs = 0;
  int m_frame = 0, m_line = 0, m_beat = 0;
  int a_frame = 0, a_line = 0;
  int rdy_mode = 0;
  bit gap_en = 0, arb_kill = 0;

  mem_vout_buffer_ctrl #(
    .ADDR_WIDTH(AWD), .MEM_DATA_BITS(DW), .BURST_LEN(BL),
    .FRAME_DEPTH_WID(FDW), .LINE_WID(LW), .FIFO_DEPTH(FD)
  ) dut (
    .ddr_clk_i(clk), .ddr_rst_n_i(rst_n), .ddr_reset_flag_i(flag),
    .wr_frame_addr_i(wr_frame), .rd_frame_addr_o(rd_frame),
    .rd_ddr_req_o(req), .rd_ddr_len_o(len), .rd_ddr_addr_o(addr),
    .rd_ddr_data_vld_i(dvld), .rd_ddr_data_i(ddata), .rd_ddr_finish_i(fin),
    .vout_vld_o(vvld), .vout_data_o(vdata), .vout_rdy_i(rdy),
    .frame_done_o(done), .vout_fifo_count_o(cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Memory arbiter: accepts a request, checks its address, returns BL beats then finish
  initial begin
    dvld = 0; fin = 0; ddata = '0;
    forever begin
      @(posedge clk); #1;
      if (!arb_kill && rst_n && req) begin
        logic [AWD-1:0] ea;
        ea = AWD'((a_frame << (LW + 9)) | (a_line << 9));
        checks++;
        if (addr !== ea || len !== 8'(BL)) begin
          failures++;
          $display("FAIL req_addr got=%0h/%0d exp=%0h/%0d", addr, len, ea, BL);
        end
        a_line = (a_line + 1) % LINES;
        if (a_line == 0) a_frame = (a_frame + 1) % (1 << FDW);
        nreq++;
        for (int b = 0; b < BL && !arb_kill; b++) begin
          if (gap_en && $urandom_range(0, 3) == 0) begin
            dvld = 0; @(posedge clk); #1;
          end
          dvld = 1; ddata = DW'(ea) + DW'(b);
          @(posedge clk); #1;
        end
        dvld = 0;
        if (!arb_kill) begin
          fin = 1; @(posedge clk); #1; fin = 0;
        end
      end
    end
  end

  // Downstream ready generator
  initial begin
    rdy = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rdy = 0;
        1:       rdy = 1;
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: every popped word against the expected frame/line/beat order
  always @(negedge clk) begin
    if (rst_n) begin
      if (vvld && rdy) begin
        logic [DW-1:0] ew;
        ew = DW'((m_frame << (LW + 9)) | (m_line << 9) | m_beat);
        checks++;
        if (vdata !== ew) begin
          failures++;
          $display("FAIL word got=%0h exp=%0h", vdata, ew);
        end
        words_out++;
        m_beat = (m_beat + 1) % BL;
        if (m_beat == 0) begin
          m_line = (m_line + 1) % LINES;
          if (m_line == 0) m_frame = (m_frame + 1) % (1 << FDW);
        end
      end
      if (done) done_cnt++;
      if ((dvld && cnt == CW'(FD) && !(vvld && rdy)) || cnt > CW'(FD)) begin
        ovf_errs++;
        $display("FAIL fifo_overflow count=%0d limit=%0d", cnt, FD);
      end
    end
  end

  task automatic test_reset();
    rst_n = 0; flag = 0; wr_frame = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req !== 1'b0)  begin failures++; $display("FAIL rst_req got=%0h exp=0", req); end
    checks++; if (len !== 8'd0)  begin failures++; $display("FAIL rst_len got=%0h exp=0", len); end
    checks++; if (addr !== '0)   begin failures++; $display("FAIL rst_addr got=%0h exp=0", addr); end
    checks++; if (rd_frame !== '0) begin failures++; $display("FAIL rst_frame got=%0h exp=0", rd_frame); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0h exp=0", done); end
    checks++; if (vvld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%0h exp=0", vvld); end
    checks++; if (cnt !== '0)    begin failures++; $display("FAIL rst_count got=%0h exp=0", cnt); end
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    rdy_mode = 1;
    wr_frame = 9'd1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL latency_req got=%0h exp=1", req); end
    for (int i = 0; i < 500 && done_cnt < 1; i++) @(negedge clk);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ff_done got=%0d exp=1", done_cnt); end
    checks++; if (rd_frame !== 9'd1) begin failures++; $display("FAIL ff_frame got=%0h exp=1", rd_frame); end
    for (int i = 0; i < 500 && words_out < WPF; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++; if (words_out !== WPF) begin failures++; $display("FAIL ff_words got=%0d exp=%0d", words_out, WPF); end
    checks++; if (nreq !== LINES) begin failures++; $display("FAIL ff_nreq got=%0d exp=%0d", nreq, LINES); end
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL ff_idle_req got=%0h exp=0", req); end
    checks++; if (cnt !== '0) begin failures++; $display("FAIL ff_empty got=%0d exp=0", cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ff_single_pulse got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int base;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    base = nreq;
    wr_frame = 9'd2;
    repeat (150) @(posedge clk);
    #1;
    checks++; if (nreq - base !== FD / BL) begin failures++; $display("FAIL bp_stall_nreq got=%0d exp=%0d", nreq - base, FD / BL); end
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL bp_stall_req got=%0h exp=0", req); end
    checks++; if (cnt !== CW'(FD)) begin failures++; $display("FAIL bp_full got=%0d exp=%0d", cnt, FD); end
    rdy_mode = 1;
    for (int i = 0; i < 600 && done_cnt < 2; i++) @(negedge clk);
    for (int i = 0; i < 600 && words_out < 2 * WPF; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++; if (nreq - base !== LINES) begin failures++; $display("FAIL bp_nreq got=%0d exp=%0d", nreq - base, LINES); end
    checks++; if (words_out !== 2 * WPF) begin failures++; $display("FAIL bp_words got=%0d exp=%0d", words_out, 2 * WPF); end
    checks++; if (rd_frame !== 9'd2) begin failures++; $display("FAIL bp_frame got=%0h exp=2", rd_frame); end
  endtask

  task automatic test_random_wrap();
    rdy_mode = 2;
    gap_en   = 1;
    wr_frame = 9'h1FF;
    for (int i = 0; i < 70000 && words_out < 511 * WPF; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (rd_frame !== 9'h1FF) begin failures++; $display("FAIL rnd_frame got=%0h exp=1ff", rd_frame); end
    checks++; if (words_out !== 511 * WPF) begin failures++; $display("FAIL rnd_words got=%0d exp=%0d", words_out, 511 * WPF); end
    checks++; if (done_cnt !== 511) begin failures++; $display("FAIL rnd_done got=%0d exp=511", done_cnt); end
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL rnd_caught_up_req got=%0h exp=0", req); end
    wr_frame = 9'h000;
    for (int i = 0; i < 1000 && words_out < 512 * WPF; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (rd_frame !== 9'h000) begin failures++; $display("FAIL wrap_frame got=%0h exp=0", rd_frame); end
    checks++; if (done_cnt !== 512) begin failures++; $display("FAIL wrap_done got=%0d exp=512", done_cnt); end
    checks++; if (nreq !== 512 * LINES) begin failures++; $display("FAIL wrap_nreq got=%0d exp=%0d", nreq, 512 * LINES); end
    checks++; if (ovf_errs !== 0) begin failures++; $display("FAIL overflow_events got=%0d exp=0", ovf_errs); end
    rdy_mode = 1;
    gap_en   = 0;
  endtask

  task automatic test_soft_reset();
    int base, dbase, wbase;
    base  = nreq;
    dbase = done_cnt;
    @(posedge clk); #1;
    wr_frame = 9'd3;
    for (int i = 0; i < 300 && nreq < base + 3; i++) @(posedge clk);
    @(posedge clk); #1;
    flag = 1; wr_frame = 9'd0;
    @(posedge clk); #1;
    flag = 0;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (nreq - base !== 3) begin failures++; $display("FAIL sr_nreq got=%0d exp=3", nreq - base); end
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL sr_req got=%0h exp=0", req); end
    checks++; if (cnt !== '0) begin failures++; $display("FAIL sr_flushed got=%0d exp=0", cnt); end
    checks++; if (vvld !== 1'b0) begin failures++; $display("FAIL sr_vld got=%0h exp=0", vvld); end
    checks++; if (rd_frame !== 9'd0) begin failures++; $display("FAIL sr_frame got=%0h exp=0", rd_frame); end
    checks++; if (done_cnt !== dbase) begin failures++; $display("FAIL sr_no_done got=%0d exp=%0d", done_cnt, dbase); end
    m_frame = 0; m_line = 0; m_beat = 0;
    a_frame = 0; a_line = 0;
    wbase = words_out;
    wr_frame = 9'd1;
    for (int i = 0; i < 600 && words_out < wbase + WPF; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++; if (words_out - wbase !== WPF) begin failures++; $display("FAIL sr_refetch_words got=%0d exp=%0d", words_out - wbase, WPF); end
    checks++; if (rd_frame !== 9'd1) begin failures++; $display("FAIL sr_refetch_frame got=%0h exp=1", rd_frame); end
  endtask

  task automatic test_async_reset();
    int base;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    base = nreq;
    wr_frame = 9'd2;
    for (int i = 0; i < 300 && nreq < base + 1; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #3;
    checks++; if (cnt === '0) begin failures++; $display("FAIL ar_precond_count got=%0d exp=nonzero", cnt); end
    arb_kill = 1;
    rst_n = 0;
    #1;
    checks++; if (req !== 1'b0)   begin failures++; $display("FAIL ar_req got=%0h exp=0", req); end
    checks++; if (len !== 8'd0)   begin failures++; $display("FAIL ar_len got=%0h exp=0", len); end
    checks++; if (addr !== '0)    begin failures++; $display("FAIL ar_addr got=%0h exp=0", addr); end
    checks++; if (rd_frame !== '0) begin failures++; $display("FAIL ar_frame got=%0h exp=0", rd_frame); end
    checks++; if (done !== 1'b0)  begin failures++; $display("FAIL ar_done got=%0h exp=0", done); end
    checks++; if (vvld !== 1'b0)  begin failures++; $display("FAIL ar_vld got=%0h exp=0", vvld); end
    checks++; if (cnt !== '0)     begin failures++; $display("FAIL ar_count got=%0d exp=0", cnt); end
  endtask

  initial begin
    rst_n = 0; flag = 0; wr_frame = '0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_random_wrap();
    test_soft_reset();
    test_async_reset();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
